// File: rtl/intdiv_pkg.sv
// Shared types and helpers for the sequential integer divider.
// Helpers work on MAX_W-bit values; callers widen and truncate with size casts.
package intdiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_DONE
   } state_e;

   localparam int unsigned EXC_DZ  = 0;
   localparam int unsigned EXC_OVF = 1;

   // Widest operand the helpers support; DATA_WIDTH must not exceed this.
   localparam int unsigned MAX_W = 64;

   function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] v);
      return ~v + MAX_W'(1);
   endfunction

   function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] v, input logic neg);
      return neg ? negate(v) : v;
   endfunction

endpackage

// File: rtl/int_div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore, and shift the quotient bit in.
module int_div_step #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] rem_i,
   input  logic [DATA_WIDTH-1:0] q_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] rem_o,
   output logic [DATA_WIDTH-1:0] q_o
);

   logic [DATA_WIDTH:0] shifted;
   logic [DATA_WIDTH:0] diff;

   always_comb begin
      shifted = {rem_i, q_i[DATA_WIDTH-1]};
      diff    = shifted - {1'b0, b_i};
      // rem < b always holds, so a negative trial result shows up in the top bit
      if (diff[DATA_WIDTH]) begin
         rem_o = shifted[DATA_WIDTH-1:0];
         q_o   = {q_i[DATA_WIDTH-2:0], 1'b0};
      end else begin
         rem_o = diff[DATA_WIDTH-1:0];
         q_o   = {q_i[DATA_WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/int_div_seq.sv
// Multi-cycle restoring divider with valid/ready handshake, signed or unsigned per request.
// Define INTDIV_EXC_EN to expose the {ovf,dz} status port out_exc_o.
module int_div_seq
   import intdiv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  kill_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic                  in_signed_i,
   input  logic [DATA_WIDTH-1:0] in_a_i,
   input  logic [DATA_WIDTH-1:0] in_b_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_q_o,
   output logic [DATA_WIDTH-1:0] out_r_o
`ifdef INTDIV_EXC_EN
   ,
   output logic [1:0]            out_exc_o
`endif
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

   state_e                state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] rem_q, quo_q, div_q;
   logic                  sign_q_q, sign_r_q;
   logic [DATA_WIDTH-1:0] out_q_q, out_r_q;
   logic                  out_valid_q;
`ifdef INTDIV_EXC_EN
   logic [1:0]            exc_q;
`endif

   logic                  a_neg, b_neg, is_dz, is_ovf;
   logic [DATA_WIDTH-1:0] a_mag, b_mag;
   logic [DATA_WIDTH-1:0] rem_step, quo_step, q_fix, r_fix;

   always_comb begin
      a_neg  = in_signed_i & in_a_i[DATA_WIDTH-1];
      b_neg  = in_signed_i & in_b_i[DATA_WIDTH-1];
      // |MIN| wraps back to MIN, which is the correct unsigned magnitude
      a_mag  = DATA_WIDTH'(abs_mag(MAX_W'(in_a_i), a_neg));
      b_mag  = DATA_WIDTH'(abs_mag(MAX_W'(in_b_i), b_neg));
      is_dz  = (in_b_i == '0);
      is_ovf = in_signed_i & (in_a_i == MIN_VAL) & (in_b_i == '1);
      q_fix  = DATA_WIDTH'(abs_mag(MAX_W'(quo_step), sign_q_q));
      r_fix  = DATA_WIDTH'(abs_mag(MAX_W'(rem_step), sign_r_q));
   end

   int_div_step #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_step (
      .rem_i(rem_q),
      .q_i  (quo_q),
      .b_i  (div_q),
      .rem_o(rem_step),
      .q_o  (quo_step)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         div_q       <= '0;
         sign_q_q    <= 1'b0;
         sign_r_q    <= 1'b0;
         out_q_q     <= '0;
         out_r_q     <= '0;
         out_valid_q <= 1'b0;
`ifdef INTDIV_EXC_EN
         exc_q       <= '0;
`endif
      end else if (kill_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
`ifdef INTDIV_EXC_EN
         exc_q       <= '0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (in_valid_i) begin
                  if (is_dz) begin
                     out_q_q     <= '1;
                     out_r_q     <= in_a_i;
                     out_valid_q <= 1'b1;
                     state_q     <= ST_DONE;
`ifdef INTDIV_EXC_EN
                     exc_q       <= 2'(1 << EXC_DZ);
`endif
                  end else if (is_ovf) begin
                     out_q_q     <= MIN_VAL;
                     out_r_q     <= '0;
                     out_valid_q <= 1'b1;
                     state_q     <= ST_DONE;
`ifdef INTDIV_EXC_EN
                     exc_q       <= 2'(1 << EXC_OVF);
`endif
                  end else begin
                     rem_q    <= '0;
                     quo_q    <= a_mag;
                     div_q    <= b_mag;
                     sign_q_q <= a_neg ^ b_neg;
                     sign_r_q <= a_neg;
                     cnt_q    <= '0;
                     state_q  <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               rem_q <= rem_step;
               quo_q <= quo_step;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  cnt_q       <= '0;
                  out_q_q     <= q_fix;
                  out_r_q     <= r_fix;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
`ifdef INTDIV_EXC_EN
                  exc_q       <= '0;
`endif
               end
            end
            ST_DONE: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready_o  = (state_q == ST_IDLE);
   assign out_valid_o = out_valid_q;
   assign out_q_o     = out_q_q;
   assign out_r_o     = out_r_q;
`ifdef INTDIV_EXC_EN
   assign out_exc_o   = exc_q;
`endif

endmodule

// File: tb/tb_int_div_seq.sv
// Directed and random stimulus for int_div_seq; expected results go through a scoreboard queue.
module tb_int_div_seq;

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic [1:0]  exc;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        kill = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_signed = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        in_ready, out_valid;
   logic [31:0] out_q, out_r;
   logic [1:0]  out_exc;

   int   n_cmp = 0;
   int   n_err = 0;
   res_t sb[$];

   always #5 clk = ~clk;

`ifndef INTDIV_EXC_EN
   assign out_exc = 2'b00;
`endif

   int_div_seq #(
      .DATA_WIDTH(32)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .kill_i     (kill),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_signed_i(in_signed),
      .in_a_i     (in_a),
      .in_b_i     (in_b),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_q_o    (out_q),
      .out_r_o    (out_r)
`ifdef INTDIV_EXC_EN
      ,
      .out_exc_o  (out_exc)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour built from SV's own division operators.
   function automatic res_t model(input logic sg, input logic [31:0] a, input logic [31:0] b);
      res_t m;
      m.exc = 2'b00;
      if (b == 32'd0) begin
         m.q = 32'hFFFF_FFFF; m.r = a; m.exc = 2'b01;
      end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         m.q = 32'h8000_0000; m.r = 32'd0; m.exc = 2'b10;
      end else if (sg) begin
         m.q = $signed(a) / $signed(b);
         m.r = $signed(a) % $signed(b);
      end else begin
         m.q = a / b;
         m.r = a % b;
      end
      return m;
   endfunction

   // Latency counts edges including the accept edge: 1 for special cases, 33 otherwise.
   task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input res_t exp, input int hold);
      res_t e;
      int   edges, lat;
      logic busy_bad, held_bad;
      lat = (exp.exc != 2'b00) ? 1 : 33;
      sb.push_back(exp);
      @(negedge clk);
      check({tag, "/in_ready_idle"}, 64'(in_ready), 64'(1));
      in_valid = 1'b1; in_signed = sg; in_a = a; in_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = ~a; in_b = ~b;
      edges = 1; busy_bad = 1'b0;
      while (!out_valid && edges < 100) begin
         if (in_ready) busy_bad = 1'b1;
         @(posedge clk); #1;
         edges++;
      end
      check({tag, "/latency"}, 64'(edges), 64'(lat));
      check({tag, "/in_ready_busy"}, 64'(busy_bad), 64'(0));
      e = sb.pop_front();
      check({tag, "/q"}, 64'(out_q), 64'(e.q));
      check({tag, "/r"}, 64'(out_r), 64'(e.r));
`ifdef INTDIV_EXC_EN
      check({tag, "/exc"}, 64'(out_exc), 64'(e.exc));
`endif
      if (hold > 0) begin
         held_bad = 1'b0;
         in_valid = 1'b1; in_a = 32'd9; in_b = 32'd3;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (out_q !== e.q || out_r !== e.r || out_valid !== 1'b1 || in_ready !== 1'b0)
               held_bad = 1'b1;
         end
         in_valid = 1'b0;
         check({tag, "/hold_stable"}, 64'(held_bad), 64'(0));
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "/valid_after_hs"}, 64'(out_valid), 64'(0));
      check({tag, "/ready_after_hs"}, 64'(in_ready), 64'(1));
   endtask

   task automatic quiet_window(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check({tag, "/no_out_valid"}, 64'(seen), 64'(0));
      check({tag, "/in_ready"}, 64'(in_ready), 64'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic        sg;
      logic [31:0] a, b;

      // Reset state
      #12;
      check("reset/out_valid", 64'(out_valid), 64'(0));
      check("reset/out_q", 64'(out_q), 64'(0));
      check("reset/out_r", 64'(out_r), 64'(0));
      check("reset/out_exc", 64'(out_exc), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("reset/in_ready", 64'(in_ready), 64'(1));

      run_op("u100_7", 1'b0, 32'd100, 32'd7, '{32'd14, 32'd2, 2'b00}, 0);
      run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 2'b00}, 0);
      run_op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, '{32'hFFFF_FFFD, 32'd1, 2'b00}, 0);
      run_op("s-7_-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, '{32'd3, 32'hFFFF_FFFF, 2'b00}, 0);
      run_op("s5_0", 1'b1, 32'd5, 32'd0, '{32'hFFFF_FFFF, 32'd5, 2'b01}, 0);
      run_op("u5_0", 1'b0, 32'd5, 32'd0, '{32'hFFFF_FFFF, 32'd5, 2'b01}, 0);
      run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, '{32'h8000_0000, 32'd0, 2'b10}, 0);
      run_op("u_min_ff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, '{32'd0, 32'h8000_0000, 2'b00}, 0);
      run_op("s_min_3", 1'b1, 32'h8000_0000, 32'd3, '{32'hD555_5556, 32'hFFFF_FFFE, 2'b00}, 0);
      run_op("hold10", 1'b0, 32'd1000, 32'd3, '{32'd333, 32'd1, 2'b00}, 10);

      // Kill at CALC cycle 5
      @(negedge clk);
      in_valid = 1'b1; in_signed = 1'b0; in_a = 32'd100; in_b = 32'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      check("kill_calc/in_ready", 64'(in_ready), 64'(1));
      quiet_window("kill_calc", 40);

      // Kill beats a same-cycle accept
      @(negedge clk);
      in_valid = 1'b1; kill = 1'b1; in_a = 32'd50; in_b = 32'd5;
      @(posedge clk); #1;
      in_valid = 1'b0; kill = 1'b0;
      quiet_window("kill_accept", 40);

      // Async reset between edges mid-CALC
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'd12345; in_b = 32'd11;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid/out_valid", 64'(out_valid), 64'(0));
      check("rst_mid/in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      rst = 1'b0;
      quiet_window("rst_mid", 40);
      run_op("u_ff_1", 1'b0, 32'hFFFF_FFFF, 32'd1, '{32'hFFFF_FFFF, 32'd0, 2'b00}, 0);

      // Random operands against the reference model
      for (int i = 0; i < 8; i++) begin
         sg = 1'($urandom_range(0, 1));
         a  = $urandom;
         b  = $urandom >> $urandom_range(0, 31);
         run_op($sformatf("rand%0d", i), sg, a, b, model(sg, a, b), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
